// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared constants and FSM encoding for the SPI receive slave
// Holds register offsets, STATUS/CTRL bit positions and the receive FSM state type.
package spi_rx_pkg;

  // Register offsets on DataAdr[1:0]
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  // STATUS bit positions
  localparam int STAT_NOTEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVR      = 2;
  localparam int STAT_BUSY     = 3;
  localparam int STAT_FERR     = 4;

  // CTRL bit positions (FLUSH and CLR are write-only pulses)
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_SHIFT = 2'd1,
    FSM_PUSH  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - byte FIFO for received SPI data
// Ports: clk, reset (sync, active high); push/push_data write one byte;
// pop removes the head; flush empties the FIFO and takes priority over
// push/pop; head is the oldest byte; full/empty/count report occupancy.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    do_push = push && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible when count_q says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 receive slave with CPU register interface
// Ports: clk, reset (sync, active high); CPU side WriteData/DataAdr/MemWrite/cs
// (cs active low) and combinational ReadData; SPI side spi_sclk/spi_mosi/spi_cs_n
// (asynchronous, synchronized internally); rx_irq high while enabled and data waits.
module spi_slave_rx
  import spi_rx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] WriteData,
  input  logic [1:0]  DataAdr,
  input  logic        MemWrite,
  input  logic        cs,
  output logic [31:0] ReadData,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        rx_irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Synchronizer chains; bit 0 takes the pin, the top bit is the usable value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_fall;

  fsm_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       en_q, en_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;

  logic       push_req, ferr_set;
  logic       pop_req, ctrl_wr, flush_req, clr_req;

  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:3];

  always_comb begin
    sclk_sync_d    = sclk_sync_q << 1;
    sclk_sync_d[0] = spi_sclk;
    mosi_sync_d    = mosi_sync_q << 1;
    mosi_sync_d[0] = spi_mosi;
    cs_sync_d      = cs_sync_q << 1;
    cs_sync_d[0]   = spi_cs_n;
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign cs_prev_d   = cs_s;
  assign sclk_rise   = sclk_s && !sclk_prev_q;
  assign cs_fall     = cs_prev_q && !cs_s;

  // CPU bus decode
  assign pop_req   = !cs && !MemWrite && (DataAdr == REG_DATA);
  assign ctrl_wr   = !cs &&  MemWrite && (DataAdr == REG_CTRL);
  assign flush_req = ctrl_wr && WriteData[CTRL_FLUSH];
  assign clr_req   = ctrl_wr && WriteData[CTRL_CLR];

  // Receive FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      FSM_IDLE: begin
        if (en_q && cs_fall) begin
          state_d   = FSM_SHIFT;
          bit_cnt_d = 3'd0;
        end
      end
      FSM_SHIFT: begin
        if (!en_q) begin
          // Disabling mid-frame silently abandons the partial byte.
          state_d   = FSM_IDLE;
          bit_cnt_d = 3'd0;
        end else if (cs_s) begin
          // Level test: also catches a frame end that arrived during PUSH.
          state_d   = FSM_IDLE;
          ferr_set  = (bit_cnt_q != 3'd0);
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = FSM_PUSH;
        end
      end
      FSM_PUSH: begin
        push_req = 1'b1;
        state_d  = FSM_SHIFT;
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // Control and sticky flags; a clear request wins over a same-cycle set.
  always_comb begin
    en_d   = ctrl_wr ? WriteData[CTRL_EN] : en_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (clr_req) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end else begin
      // Full FIFO drops the byte unless a pop frees room or a flush discards all.
      if (push_req && fifo_full && !pop_req && !flush_req) ovr_d = 1'b1;
      if (ferr_set) ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= FSM_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      en_q        <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      en_q        <= en_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift_q),
    .pop       (pop_req),
    .flush     (flush_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register read mux; silent unless this is a CPU load aimed at us.
  always_comb begin
    ReadData = 32'd0;
    if (!cs && !MemWrite) begin
      case (DataAdr)
        REG_STATUS: begin
          ReadData[STAT_NOTEMPTY] = !fifo_empty;
          ReadData[STAT_FULL]     = fifo_full;
          ReadData[STAT_OVR]      = ovr_q;
          ReadData[STAT_BUSY]     = (state_q != FSM_IDLE);
          ReadData[STAT_FERR]     = ferr_q;
        end
        REG_DATA:  if (!fifo_empty) ReadData[7:0] = fifo_head;
        REG_CTRL:  ReadData[CTRL_EN] = en_q;
        REG_COUNT: ReadData[CNT_W-1:0] = fifo_count;
        default:   ReadData = 32'd0;
      endcase
    end
  end

  assign rx_irq = en_q && !fifo_empty;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx against a queue-based model
module tb_spi_slave_rx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteData;
  logic [1:0]  DataAdr;
  logic        MemWrite;
  logic        cs;
  logic [31:0] ReadData;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        rx_irq;

  always #5 clk = ~clk;

  spi_slave_rx #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .WriteData (WriteData),
    .DataAdr   (DataAdr),
    .MemWrite  (MemWrite),
    .cs        (cs),
    .ReadData  (ReadData),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .rx_irq    (rx_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: received bytes in arrival order plus flags.
  byte unsigned m_q[$];
  bit m_en, m_ovr, m_ferr, m_in_frame;
  int m_bits;
  bit quiet = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, m_ferr, m_in_frame, m_ovr, (m_q.size() == DEPTH), (m_q.size() != 0)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (!reset && (cs || MemWrite)) check("rdata_quiet", ReadData, 32'd0);
    if (quiet && !reset) check("rx_irq", {31'b0, rx_irq}, {31'b0, (m_en && m_q.size() != 0)});
  end

  task automatic settle();
    @(negedge clk);
    quiet = 1'b1;
  endtask

  task automatic rd(input logic [1:0] adr, output logic [31:0] data);
    @(negedge clk);
    quiet = 1'b0; cs = 1'b0; MemWrite = 1'b0; DataAdr = adr;
    #1 data = ReadData;
    @(negedge clk);
    cs = 1'b1; DataAdr = 2'd0;
  endtask

  task automatic reg_chk(input logic [1:0] adr, input string name, output logic [31:0] v);
    logic [31:0] e;
    case (adr)
      2'd0:    e = m_status();
      2'd1:    e = (m_q.size() != 0) ? {24'b0, m_q[0]} : 32'd0;
      2'd2:    e = {31'b0, m_en};
      default: e = 32'(m_q.size());
    endcase
    rd(adr, v);
    if (adr == 2'd1 && m_q.size() != 0) void'(m_q.pop_front());
    check(name, v, e);
    settle();
  endtask

  task automatic wr_ctrl(input logic [31:0] val);
    @(negedge clk);
    quiet = 1'b0; cs = 1'b0; MemWrite = 1'b1; DataAdr = 2'd2; WriteData = val;
    @(negedge clk);
    cs = 1'b1; MemWrite = 1'b0; WriteData = 32'd0; DataAdr = 2'd0;
    m_en = val[0];
    if (val[1]) m_q.delete();
    if (val[2]) begin m_ovr = 1'b0; m_ferr = 1'b0; end
    if (!m_en) begin m_in_frame = 1'b0; m_bits = 0; end
    settle();
  endtask

  task automatic frame_start();
    quiet = 1'b0;
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    if (m_en) begin m_in_frame = 1'b1; m_bits = 0; end
    quiet = 1'b1;
  endtask

  task automatic frame_end();
    quiet = 1'b0;
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    if (m_in_frame && (m_bits % 8) != 0) m_ferr = 1'b1;
    m_in_frame = 1'b0;
    m_bits = 0;
    quiet = 1'b1;
  endtask

  // Mode 0 at clk/8: MOSI changes while SCLK is low, 4 clk low + 4 clk high.
  // With pop_at_push, a DATA read is placed in the cycle the 8th bit is pushed.
  task automatic send_bits(input logic [7:0] b, input int n, input bit pop_at_push,
                           output logic [31:0] popped);
    quiet = 1'b0;
    popped = 32'd0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      if (pop_at_push && i == 7) begin
        repeat (3) @(negedge clk);
        cs = 1'b0; MemWrite = 1'b0; DataAdr = 2'd1;
        #1 popped = ReadData;
        @(negedge clk);
        cs = 1'b1; DataAdr = 2'd0;
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [31:0] dummy;
    send_bits(b, 8, 1'b0, dummy);
    if (m_in_frame) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovr = 1'b1;
    end
    quiet = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    logic [31:0] dummy;
    send_bits(b, n, 1'b0, dummy);
    if (m_in_frame) m_bits += n;
    quiet = 1'b1;
  endtask

  task automatic do_reset();
    quiet = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_q.delete();
    m_en = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_in_frame = 1'b0; m_bits = 0;
    settle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] pd;
    logic [7:0]  exp_head;
    int          k;
    reset = 1'b1; WriteData = 32'd0; DataAdr = 2'd0; MemWrite = 1'b0; cs = 1'b1;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    m_en = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_in_frame = 1'b0; m_bits = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    #1 check("reset_irq", {31'b0, rx_irq}, 32'd0);
    reg_chk(2'd0, "reset_status", v); check("lit_reset_status", v, 32'h0);
    reg_chk(2'd3, "reset_count", v);  check("lit_reset_count", v, 32'h0);
    reg_chk(2'd2, "reset_ctrl", v);   check("lit_reset_ctrl", v, 32'h0);

    // Single byte 0xA5
    wr_ctrl(32'h1);
    frame_start();
    send_byte(8'hA5);
    reg_chk(2'd0, "a5_status_in_frame", v); check("lit_a5_status", v, 32'h09);
    frame_end();
    reg_chk(2'd3, "a5_count", v); check("lit_a5_count", v, 32'h1);
    reg_chk(2'd1, "a5_data", v);  check("lit_a5_data", v, 32'hA5);
    reg_chk(2'd0, "a5_status_after", v); check("lit_a5_status_after", v, 32'h0);

    // Overflow: 5 bytes into a 4-deep FIFO
    frame_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    frame_end();
    reg_chk(2'd3, "ovr_count", v);  check("lit_ovr_count", v, 32'h4);
    reg_chk(2'd0, "ovr_status", v); check("lit_ovr_status", v, 32'h07);
    for (int i = 1; i <= 4; i++) begin
      reg_chk(2'd1, "ovr_data", v); check("lit_ovr_data", v, 32'(i));
    end
    reg_chk(2'd1, "ovr_empty_data", v); check("lit_ovr_no_5", v, 32'h0);
    wr_ctrl(32'h5);

    // Framing error after 3 bits
    frame_start();
    send_partial(8'hE0, 3);
    frame_end();
    reg_chk(2'd0, "ferr_status", v); check("lit_ferr_status", v, 32'h10);
    reg_chk(2'd3, "ferr_count", v);  check("lit_ferr_count", v, 32'h0);
    wr_ctrl(32'h5);
    reg_chk(2'd0, "ferr_cleared", v); check("lit_ferr_cleared", v, 32'h0);

    // Pop coinciding with push into a full FIFO
    frame_start();
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
    exp_head = m_q[0];
    send_bits(8'h15, 8, 1'b1, pd);
    check("simul_pop_data", pd, {24'b0, exp_head});
    check("lit_simul_pop", pd, 32'h11);
    void'(m_q.pop_front());
    m_q.push_back(8'h15);
    quiet = 1'b1;
    frame_end();
    reg_chk(2'd0, "simul_status", v); check("lit_simul_status", v, 32'h03);
    reg_chk(2'd3, "simul_count", v);  check("lit_simul_count", v, 32'h4);
    for (int i = 0; i < 4; i++) begin
      reg_chk(2'd1, "simul_order", v); check("lit_simul_order", v, 32'h12 + 32'(i));
    end

    // Empty reads and deselected reads
    reg_chk(2'd1, "empty_data", v); check("lit_empty_data", v, 32'h0);
    reg_chk(2'd3, "empty_count", v);
    @(negedge clk);
    quiet = 1'b0; cs = 1'b1; MemWrite = 1'b0; DataAdr = 2'd0;
    #1 check("cs_high_read", ReadData, 32'h0);
    @(negedge clk);
    cs = 1'b0; MemWrite = 1'b1; DataAdr = 2'd3; WriteData = 32'hFFFF_FFF0;
    #1 check("memwrite_read", ReadData, 32'h0);
    @(negedge clk);
    cs = 1'b1; MemWrite = 1'b0; WriteData = 32'd0; DataAdr = 2'd0;
    settle();

    // Disable mid-frame: no FERR
    frame_start();
    send_partial(8'hC0, 3);
    wr_ctrl(32'h0);
    reg_chk(2'd0, "dis_status", v); check("lit_dis_status", v, 32'h0);
    frame_end();
    reg_chk(2'd0, "dis_status_end", v); check("lit_dis_end", v, 32'h0);
    wr_ctrl(32'h1);

    // Flush
    frame_start();
    send_byte(8'h5A);
    send_byte(8'hC3);
    frame_end();
    wr_ctrl(32'h3);
    reg_chk(2'd3, "flush_count", v); check("lit_flush_count", v, 32'h0);

    // Reset mid-byte, then a clean 0x3C
    frame_start();
    send_partial(8'hFF, 4);
    do_reset();
    frame_end();
    reg_chk(2'd0, "rst_status", v); check("lit_rst_status", v, 32'h0);
    wr_ctrl(32'h1);
    frame_start();
    send_byte(8'h3C);
    frame_end();
    reg_chk(2'd3, "rst_count", v);  check("lit_rst_count", v, 32'h1);
    reg_chk(2'd1, "rst_data", v);   check("lit_rst_data", v, 32'h3C);
    reg_chk(2'd0, "rst_status2", v); check("lit_rst_status2", v, 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          frame_start();
          k = $urandom_range(1, 3);
          for (int j = 0; j < k; j++) send_byte(8'($urandom));
          if ($urandom_range(0, 1) == 1) send_partial(8'($urandom), $urandom_range(1, 7));
          reg_chk(2'd0, "rnd_status_frame", v);
          frame_end();
        end
        1: reg_chk(2'd1, "rnd_data", v);
        2: reg_chk(2'd0, "rnd_status", v);
        3: reg_chk(2'd3, "rnd_count", v);
        4: wr_ctrl({29'b0, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0)});
        default: reg_chk(2'd2, "rnd_ctrl", v);
      endcase
    end
    while (m_q.size() != 0) reg_chk(2'd1, "drain_data", v);
    reg_chk(2'd3, "drain_count", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning receive FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per SPI input.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 WriteData  input  32  CPU store data.
REQ-007 DataAdr  input  2  register offset, DataAdr[1:0].
REQ-008 MemWrite  input  1  CPU store strobe.
REQ-009 cs  input  1  active-low select from the address decoder, region 0x6000_0000 (cs[6]).
REQ-010 ReadData  output  32  register read data.
REQ-011 spi_sclk  input  1  external SPI clock, asynchronous.
REQ-012 spi_mosi  input  1  external serial data, asynchronous.
REQ-013 spi_cs_n  input  1  external frame select, active low, asynchronous.
REQ-014 rx_irq  output  1  high while enabled and FIFO not empty.

Function
REQ-015 SHALL pass spi_sclk, spi_mosi and spi_cs_n through SYNC_STAGES flops before use.
REQ-016 SHALL implement SPI mode 0: sample MOSI on the synchronized rising SCLK edge, MSB first, 8 bits per byte.
REQ-017 SHALL support SCLK up to clk/8.
REQ-018 SHALL use FSM IDLE/SHIFT/PUSH: IDLE->SHIFT on synchronized cs_n falling while enabled; SHIFT->PUSH on eighth sampled bit; PUSH->SHIFT after one cycle; SHIFT->IDLE on cs_n rising.
REQ-019 SHALL, in PUSH, write the assembled byte into the FIFO if not full; if full, drop the byte and set sticky OVR.
REQ-020 SHALL, on cs_n rising with 1..7 bits captured, discard the partial byte and set sticky FERR.
REQ-021 SHALL decode registers when cs==0: offset 0 STATUS (read), 1 DATA (read), 2 CTRL (read/write), 3 COUNT (read).
REQ-022 STATUS SHALL be {27'b0, FERR[4], BUSY[3], OVR[2], FULL[1], NOTEMPTY[0]}; BUSY = FSM not IDLE.
REQ-023 DATA read SHALL return {24'b0, FIFO head} combinationally and pop the FIFO on the clock edge where cs==0, MemWrite==0, DataAdr==1.
REQ-024 DATA read when empty SHALL return 0 and SHALL NOT pop or change state.
REQ-025 CTRL write SHALL set EN=WriteData[0]; WriteData[1]=1 flushes FIFO; WriteData[2]=1 clears OVR and FERR; bits 1-2 self-clear, CTRL reads {31'b0, EN}.
REQ-026 COUNT SHALL return FIFO occupancy 0..DEPTH, zero-extended.
REQ-027 ReadData SHALL be 0 whenever cs==1 or MemWrite==1.
REQ-028 Simultaneous PUSH and pop with FIFO full SHALL accept the push without OVR; occupancy unchanged.
REQ-029 Simultaneous flush and PUSH SHALL leave the FIFO empty (flush wins).
REQ-030 Clearing EN mid-frame SHALL return FSM to IDLE, discard the partial byte, without setting FERR.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter SHALL never exceed DEPTH or underflow.

Reset
REQ-032 Reset SHALL clear FSM to IDLE, bit counter, shift register, FIFO pointers/count, OVR, FERR, EN=0, synchronizers to idle (sclk 0, cs_n 1).
REQ-033 After reset, ReadData=0 and rx_irq=0; reset mid-frame SHALL discard all data, with no flag set.

Structure
REQ-034 Package spi_rx_pkg SHALL hold register offsets, STATUS bit positions, CTRL bit positions and the FSM state enum.
REQ-035 FIFO SHALL be a sub-module rx_fifo (DEPTH parameter, push/pop/flush, full/empty/count).

Verification
REQ-036 EN=1, frame cs_n low, send 0xA5 at clk/8 -> STATUS=0x09 during frame, COUNT=1, DATA read returns 0xA5, then STATUS=0x00.
REQ-037 Send 5 bytes 0x01..0x05 with DEPTH=4, no reads -> COUNT=4, OVR=1, reads return 0x01..0x04, 0x05 absent.
REQ-038 Raise cs_n after 3 bits -> FERR=1, COUNT=0; CTRL write 0x5 -> STATUS=0x00.
REQ-039 FIFO full, pop on same cycle as PUSH -> OVR=0, COUNT stays 4, order preserved.
REQ-040 Read DATA when empty -> ReadData=0, COUNT=0; cs=1 read -> ReadData=0.
REQ-041 Assert reset mid-byte after 4 bits, then send 0x3C -> only 0x3C received after EN re-set, flags 0.
